// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants, field positions and control decode for id_ex_stage.
package id_ex_stage_pkg;

  localparam int DSIZE  = 32;
  localparam int ASIZE  = 5;
  localparam int ISIZE  = 32;
  localparam int PCSIZE = 32;
  localparam int OPSIZE = 6;

  localparam logic [OPSIZE-1:0] OP_NOP  = 6'h00;
  localparam logic [OPSIZE-1:0] OP_ALU  = 6'h01;
  localparam logic [OPSIZE-1:0] OP_BEQ  = 6'h04;
  localparam logic [OPSIZE-1:0] OP_ADDI = 6'h08;
  localparam logic [OPSIZE-1:0] OP_LW   = 6'h23;
  localparam logic [OPSIZE-1:0] OP_SW   = 6'h2b;

  // Instruction field bit positions
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RD_HI  = 25;
  localparam int RD_LO  = 21;
  localparam int RS1_HI = 20;
  localparam int RS1_LO = 16;
  localparam int RS2_HI = 15;
  localparam int RS2_LO = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef struct packed {
    logic [OPSIZE-1:0] op;
    logic              uses_rs1;
    logic              uses_rs2;
    logic              wen;
    logic              memread;
    logic              memwrite;
  } ctl_t;

  // Opcode to control; unknown opcodes collapse to a NOP with no side effects
  function automatic ctl_t decode_ctl(logic [OPSIZE-1:0] op);
    ctl_t c;
    c = '0;
    c.op = OP_NOP;
    case (op)
      OP_ALU:  begin c.op = OP_ALU;  c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.wen = 1'b1; end
      OP_ADDI: begin c.op = OP_ADDI; c.uses_rs1 = 1'b1; c.wen = 1'b1; end
      OP_LW:   begin c.op = OP_LW;   c.uses_rs1 = 1'b1; c.wen = 1'b1; c.memread = 1'b1; end
      OP_SW:   begin c.op = OP_SW;   c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.memwrite = 1'b1; end
      OP_BEQ:  begin c.op = OP_BEQ;  c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
      default: c.op = OP_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: the load sitting in ID/EX writes a register that the
// instruction in decode reads, so its data is not available yet.
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int ASIZE = id_ex_stage_pkg::ASIZE
) (
  input  logic             if_valid,
  input  logic [ASIZE-1:0] rs1,
  input  logic [ASIZE-1:0] rs2,
  input  logic             uses_rs1,
  input  logic             uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [ASIZE-1:0] ex_rd,
  output logic             hz
);

  // r0 is hardwired, so a load targeting it never creates a dependency
  assign hz = if_valid & ex_valid & ex_memread & (ex_rd != '0) &
              (((ex_rd == rs1) & uses_rs1) | ((ex_rd == rs2) & uses_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register with load-use stall, flush and hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DSIZE  = id_ex_stage_pkg::DSIZE,
  parameter int ASIZE  = id_ex_stage_pkg::ASIZE,
  parameter int ISIZE  = id_ex_stage_pkg::ISIZE,
  parameter int PCSIZE = id_ex_stage_pkg::PCSIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [ISIZE-1:0]  if_instr,
  input  logic [PCSIZE-1:0] if_pc,
  output logic [ASIZE-1:0]  raddr1,
  output logic [ASIZE-1:0]  raddr2,
  input  logic [DSIZE-1:0]  rdata1,
  input  logic [DSIZE-1:0]  rdata2,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic [5:0]        ex_op,
  output logic [ASIZE-1:0]  ex_rd,
  output logic [ASIZE-1:0]  ex_rs1,
  output logic [ASIZE-1:0]  ex_rs2,
  output logic [DSIZE-1:0]  ex_a,
  output logic [DSIZE-1:0]  ex_b,
  output logic [DSIZE-1:0]  ex_imm,
  output logic              ex_wen,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [PCSIZE-1:0] ex_pc
);

  logic [ASIZE-1:0] rd, rs1, rs2;
  logic [15:0]      imm;
  ctl_t             ctl;
  logic             hz;

  assign rd  = if_instr[RD_HI:RD_LO];
  assign rs1 = if_instr[RS1_HI:RS1_LO];
  assign rs2 = if_instr[RS2_HI:RS2_LO];
  assign imm = if_instr[IMM_HI:IMM_LO];
  assign ctl = decode_ctl(if_instr[OP_HI:OP_LO]);

  // Register file read ports follow IF/ID regardless of its valid bit
  assign raddr1 = rs1;
  assign raddr2 = rs2;

  hazard_detect #(.ASIZE(ASIZE)) u_hazard_detect (
    .if_valid   (if_valid),
    .rs1        (rs1),
    .rs2        (rs2),
    .uses_rs1   (ctl.uses_rs1),
    .uses_rs2   (ctl.uses_rs2),
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .hz         (hz)
  );

  // A flush kills decode, so IF must be released even if a hazard or hold exists
  assign stall = (hz | ex_hold) & ~flush;

  // ID/EX register: flush > hold > bubble > load; bubbles keep data fields
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_a        <= '0;
      ex_b        <= '0;
      ex_imm      <= '0;
      ex_wen      <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_pc       <= '0;
    end else if (flush || (!ex_hold && hz)) begin
      ex_valid    <= 1'b0;
      ex_wen      <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid    <= if_valid;
      ex_op       <= ctl.op;
      ex_rd       <= rd;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_a        <= rdata1;
      ex_b        <= rdata2;
      ex_imm      <= {{(DSIZE-16){imm[15]}}, imm};
      // Controls are gated by valid so an empty slot never writes anything
      ex_wen      <= if_valid & ctl.wen & (rd != '0);
      ex_memread  <= if_valid & ctl.memread;
      ex_memwrite <= if_valid & ctl.memwrite;
      ex_pc       <= if_pc;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stimulus pushes expectations, a monitor checks.
`timescale 1ns/1ps
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1 = '0, rdata2 = '0;
  logic        flush = 1'b0, ex_hold = 1'b0;
  logic        stall, ex_valid;
  logic [5:0]  ex_op;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_a, ex_b, ex_imm, ex_pc;
  logic        ex_wen, ex_memread, ex_memwrite;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
    .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_wen(ex_wen),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_pc(ex_pc)
  );

  always #10 clk = ~clk;

  typedef struct {
    time         t;
    string       name;
    bit          full;
    logic        stall;
    logic [4:0]  ra1, ra2;
    logic        valid;
    logic [5:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] a, b, imm;
    logic        wen, mr, mw;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] enc_r(logic [5:0] op, logic [4:0] rd, logic [4:0] s1, logic [4:0] s2);
    return {op, rd, s1, s2, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rd, logic [4:0] s1, logic [15:0] im);
    return {op, rd, s1, im};
  endfunction

  task automatic chk(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h", n, f, act, exp);
    end
  endtask

  // Monitor: compares every expectation once its sample time arrives
  initial begin
    exp_t e;
    forever begin
      #1;
      while (q.size() != 0 && q[0].t <= $time) begin
        e = q.pop_front();
        chk(e.name, "stall",  {31'd0, stall},      {31'd0, e.stall});
        chk(e.name, "raddr1", {27'd0, raddr1},     {27'd0, e.ra1});
        chk(e.name, "raddr2", {27'd0, raddr2},     {27'd0, e.ra2});
        chk(e.name, "valid",  {31'd0, ex_valid},   {31'd0, e.valid});
        chk(e.name, "wen",    {31'd0, ex_wen},     {31'd0, e.wen});
        chk(e.name, "memrd",  {31'd0, ex_memread}, {31'd0, e.mr});
        chk(e.name, "memwr",  {31'd0, ex_memwrite},{31'd0, e.mw});
        if (e.full) begin
          chk(e.name, "op",  {26'd0, ex_op},  {26'd0, e.op});
          chk(e.name, "rd",  {27'd0, ex_rd},  {27'd0, e.rd});
          chk(e.name, "rs1", {27'd0, ex_rs1}, {27'd0, e.rs1});
          chk(e.name, "rs2", {27'd0, ex_rs2}, {27'd0, e.rs2});
          chk(e.name, "a",   ex_a,   e.a);
          chk(e.name, "b",   ex_b,   e.b);
          chk(e.name, "imm", ex_imm, e.imm);
          chk(e.name, "pc",  ex_pc,  e.pc);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(logic v, logic [31:0] ins, logic [31:0] pc, logic [31:0] r1,
                     logic [31:0] r2, logic fl, logic hd);
    if_valid = v; if_instr = ins; if_pc = pc;
    rdata1 = r1; rdata2 = r2; flush = fl; ex_hold = hd;
  endtask

  task automatic exp_full(string n, logic st, logic [4:0] ra1, logic [4:0] ra2,
                          logic v, logic [5:0] op, logic [4:0] rd, logic [4:0] s1,
                          logic [4:0] s2, logic [31:0] a, logic [31:0] b,
                          logic [31:0] im, logic w, logic mr, logic mw, logic [31:0] pc);
    exp_t e;
    e.t = $time + 2; e.name = n; e.full = 1'b1; e.stall = st; e.ra1 = ra1; e.ra2 = ra2;
    e.valid = v; e.op = op; e.rd = rd; e.rs1 = s1; e.rs2 = s2; e.a = a; e.b = b;
    e.imm = im; e.wen = w; e.mr = mr; e.mw = mw; e.pc = pc;
    q.push_back(e);
  endtask

  task automatic exp_ctl(string n, logic st, logic [4:0] ra1, logic [4:0] ra2,
                         logic v, logic w, logic mr, logic mw);
    exp_t e;
    e = '{default: '0};
    e.t = $time + 2; e.name = n; e.full = 1'b0; e.stall = st; e.ra1 = ra1; e.ra2 = ra2;
    e.valid = v; e.wen = w; e.mr = mr; e.mw = mw;
    q.push_back(e);
  endtask

  initial begin
    logic [31:0] i_addi, i_lw5, i_alu6, i_lw0, i_alu7, i_lw9, i_sw, i_addi10, i_beq, i_lw11, i_addi12;
    i_addi   = enc_i(OP_ADDI, 5'd4, 5'd1, 16'd7);
    i_lw5    = enc_i(OP_LW, 5'd5, 5'd8, 16'd0);
    i_alu6   = enc_r(OP_ALU, 5'd6, 5'd5, 5'd2);
    i_lw0    = enc_i(OP_LW, 5'd0, 5'd3, 16'd4);
    i_alu7   = enc_r(OP_ALU, 5'd7, 5'd0, 5'd0);
    i_lw9    = enc_i(OP_LW, 5'd9, 5'd1, 16'd0);
    i_sw     = enc_r(OP_SW, 5'd0, 5'd2, 5'd9);
    i_addi10 = enc_i(OP_ADDI, 5'd10, 5'd2, 16'hffff);
    i_beq    = enc_r(OP_BEQ, 5'd0, 5'd1, 5'd2);
    i_lw11   = enc_i(OP_LW, 5'd11, 5'd1, 16'd0);
    i_addi12 = enc_i(OP_ADDI, 5'd12, 5'd11, 16'd1);

    #1;
    exp_full("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ADDI r4,r1,#7
    cyc(); rst = 1'b0; drv(1, i_addi, 32'h100, 32'd1, 32'h55, 0, 0);
    exp_full("addi_in", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_full("addi_out", 0, 0, 0, 1, OP_ADDI, 4, 1, 0, 32'd1, 32'h55, 32'd7, 1, 0, 0, 32'h100);

    // LW r5 then ALU r6,r5,r2: one bubble
    cyc(); drv(1, i_lw5, 32'h104, 32'h1000, 0, 0, 0);
    exp_ctl("idle", 0, 8, 0, 0, 0, 0, 0);
    cyc(); drv(1, i_alu6, 32'h108, 32'haaaa, 32'h22, 0, 0);
    exp_full("lw5_out", 1, 5, 2, 1, OP_LW, 5, 8, 0, 32'h1000, 0, 0, 1, 1, 0, 32'h104);
    cyc(); drv(1, i_alu6, 32'h108, 32'h77, 32'h22, 0, 0);
    exp_ctl("bubble", 0, 5, 2, 0, 0, 0, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_full("alu6_out", 0, 0, 0, 1, OP_ALU, 6, 5, 2, 32'h77, 32'h22, 32'h1000, 1, 0, 0, 32'h108);

    // LW r0 then ALU using r0: no stall
    cyc(); drv(1, i_lw0, 32'h200, 32'h10, 0, 0, 0);
    exp_ctl("idle2", 0, 3, 0, 0, 0, 0, 0);
    cyc(); drv(1, i_alu7, 32'h204, 0, 0, 0, 0);
    exp_full("lw0_out", 0, 0, 0, 1, OP_LW, 0, 3, 0, 32'h10, 0, 32'd4, 0, 1, 0, 32'h200);
    cyc(); drv(1, i_lw9, 32'h208, 32'h30, 0, 0, 0);
    exp_full("alu7_out", 0, 1, 0, 1, OP_ALU, 7, 0, 0, 0, 0, 0, 1, 0, 0, 32'h204);

    // SW needing r9 (rs2) while flush is asserted
    cyc(); drv(1, i_sw, 32'h20c, 32'h40, 32'h50, 1, 0);
    exp_full("lw9_flush", 0, 2, 9, 1, OP_LW, 9, 1, 0, 32'h30, 0, 0, 1, 1, 0, 32'h208);
    cyc(); drv(1, i_sw, 32'h20c, 32'h40, 32'h50, 0, 0);
    exp_ctl("flushed", 0, 2, 9, 0, 0, 0, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_full("sw_out", 0, 0, 0, 1, OP_SW, 0, 2, 9, 32'h40, 32'h50, 32'h4800, 0, 0, 1, 32'h20c);

    // ex_hold for three edges
    cyc(); drv(1, i_addi10, 32'h300, 32'd5, 0, 0, 0);
    exp_ctl("idle3", 0, 2, 31, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(); drv(1, i_beq, 32'h304, 32'h11, 32'h22, 0, 1);
      exp_full("hold", 1, 1, 2, 1, OP_ADDI, 10, 2, 31, 32'd5, 0, 32'hffffffff, 1, 0, 0, 32'h300);
    end
    cyc(); drv(1, i_beq, 32'h304, 32'h11, 32'h22, 0, 0);
    exp_full("hold_rel", 0, 1, 2, 1, OP_ADDI, 10, 2, 31, 32'd5, 0, 32'hffffffff, 1, 0, 0, 32'h300);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_full("beq_out", 0, 0, 0, 1, OP_BEQ, 0, 1, 2, 32'h11, 32'h22, 32'h1000, 0, 0, 0, 32'h304);

    // Asynchronous reset during a load-use stall
    cyc(); drv(1, i_lw11, 32'h400, 32'h60, 0, 0, 0);
    exp_ctl("idle4", 0, 1, 0, 0, 0, 0, 0);
    cyc(); drv(1, i_addi12, 32'h404, 0, 0, 0, 0);
    exp_full("lw11_out", 1, 11, 0, 1, OP_LW, 11, 1, 0, 32'h60, 0, 0, 1, 1, 0, 32'h400);
    #3; rst = 1'b1;
    exp_full("async_rst", 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); rst = 1'b0; drv(1, i_addi12, 32'h404, 32'h99, 0, 0, 0);
    exp_full("rst_hold", 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    exp_full("post_rst", 0, 0, 0, 1, OP_ADDI, 12, 11, 0, 32'h99, 0, 32'd1, 1, 0, 0, 32'h404);

    for (int k = 0; k < 50 && q.size() != 0; k++) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
